// File: rtl/mand_dispatcher_pkg.sv
// Shared types and constants for the Mandelbrot frame dispatcher.
// Coordinates are signed Q4.23 fixed point held in COORD_W-bit two's complement.
package mand_dispatcher_pkg;
   localparam int COORD_W = 27;
   localparam int FRAC_W  = 23;
   localparam logic [31:0] RESULT_CONVERGED = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      EMIT   = 2'd3
   } state_e;
endpackage

// File: rtl/mand_coord_gen.sv
// Raster-order pixel counters and c accumulators for the dispatcher.
// load restarts the walk at (0,0) with fresh config; advance steps one pixel.
module mand_coord_gen
   import mand_dispatcher_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XW     = 10,
   parameter int YW     = 9
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               advance,
   input  logic [COORD_W-1:0] x_min,
   input  logic [COORD_W-1:0] y_max,
   input  logic [COORD_W-1:0] step,
   output logic [XW-1:0]      x,
   output logic [YW-1:0]      y,
   output logic [COORD_W-1:0] c_re,
   output logic [COORD_W-1:0] c_im,
   output logic               last_in_row,
   output logic               last_pixel
);
   logic [XW-1:0]      x_q, x_d;
   logic [YW-1:0]      y_q, y_d;
   logic [COORD_W-1:0] c_re_q, c_re_d;
   logic [COORD_W-1:0] c_im_q, c_im_d;
   logic [COORD_W-1:0] x_min_q, x_min_d;
   logic [COORD_W-1:0] step_q, step_d;

   assign last_in_row = (x_q == XW'(WIDTH - 1));
   assign last_pixel  = last_in_row && (y_q == YW'(HEIGHT - 1));
   assign x    = x_q;
   assign y    = y_q;
   assign c_re = c_re_q;
   assign c_im = c_im_q;

   always_comb begin
      x_d     = x_q;
      y_d     = y_q;
      c_re_d  = c_re_q;
      c_im_d  = c_im_q;
      x_min_d = x_min_q;
      step_d  = step_q;
      if (load) begin
         x_min_d = x_min;
         step_d  = step;
         x_d     = '0;
         y_d     = '0;
         c_re_d  = x_min;
         c_im_d  = y_max;
      end else if (advance) begin
         // Row wrap: imaginary axis walks downward from y_max.
         if (last_in_row) begin
            x_d    = '0;
            y_d    = y_q + 1'b1;
            c_re_d = x_min_q;
            c_im_d = c_im_q - step_q;
         end else begin
            x_d    = x_q + 1'b1;
            c_re_d = c_re_q + step_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_q     <= '0;
         y_q     <= '0;
         c_re_q  <= '0;
         c_im_q  <= '0;
         x_min_q <= '0;
         step_q  <= '0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         c_re_q  <= c_re_d;
         c_im_q  <= c_im_d;
         x_min_q <= x_min_d;
         step_q  <= step_d;
      end
   end
endmodule

// File: rtl/mand_dispatcher.sv
// Frame-level initiator for one mand_solver: raster walk, solver launch, pixel stream.
// Optional MAND_DISPATCHER_STATS_EN adds converged_cnt and max_count outputs.
module mand_dispatcher
   import mand_dispatcher_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int XW     = 10,
   parameter int YW     = 9
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [COORD_W-1:0] x_min,
   input  logic [COORD_W-1:0] y_max,
   input  logic [COORD_W-1:0] step,
   input  logic [9:0]         iter_limit,
   output logic               busy,
   output logic               frame_done,
   output logic               solver_reset,
   output logic [COORD_W-1:0] solver_c_re,
   output logic [COORD_W-1:0] solver_c_im,
   output logic [9:0]         solver_iters,
   input  logic               solver_out_ready,
   input  logic [31:0]        solver_out,
   // pix stream: a record transfers on a clock edge with pix_valid and pix_ready
   // both high; pix_valid/pix_x/pix_y/pix_count hold until then.
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic [XW-1:0]      pix_x,
   output logic [YW-1:0]      pix_y,
   output logic [31:0]        pix_count,
`ifdef MAND_DISPATCHER_STATS_EN
   output logic [31:0]        converged_cnt,
   output logic [31:0]        max_count,
`endif
   output logic [1:0]         dbg_state
);
   state_e        state_q, state_d;
   logic          frame_done_q, frame_done_d;
   logic          pix_valid_q, pix_valid_d;
   logic [XW-1:0] pix_x_q, pix_x_d;
   logic [YW-1:0] pix_y_q, pix_y_d;
   logic [31:0]   pix_count_q, pix_count_d;
   logic [9:0]    iters_q, iters_d;
   logic          cg_load, cg_advance, cg_last_in_row, cg_last_pixel;
   logic [XW-1:0] cg_x;
   logic [YW-1:0] cg_y;

   mand_coord_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW)) u_coord (
      .clock       (clock),
      .reset       (reset),
      .load        (cg_load),
      .advance     (cg_advance),
      .x_min       (x_min),
      .y_max       (y_max),
      .step        (step),
      .x           (cg_x),
      .y           (cg_y),
      .c_re        (solver_c_re),
      .c_im        (solver_c_im),
      .last_in_row (cg_last_in_row),
      .last_pixel  (cg_last_pixel)
   );

   assign busy         = (state_q != IDLE);
   assign solver_reset = (state_q == LAUNCH);
   assign frame_done   = frame_done_q;
   assign solver_iters = iters_q;
   assign pix_valid    = pix_valid_q;
   assign pix_x        = pix_x_q;
   assign pix_y        = pix_y_q;
   assign pix_count    = pix_count_q;
   assign dbg_state    = state_q;

   always_comb begin
      state_d      = state_q;
      frame_done_d = 1'b0;
      pix_valid_d  = pix_valid_q;
      pix_x_d      = pix_x_q;
      pix_y_d      = pix_y_q;
      pix_count_d  = pix_count_q;
      iters_d      = iters_q;
      cg_load      = 1'b0;
      cg_advance   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               iters_d = iter_limit;
               cg_load = 1'b1;
               state_d = LAUNCH;
            end
         end
         // solver_out_ready may still show the previous pixel here, so skip it.
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (solver_out_ready) begin
               pix_count_d = solver_out;
               pix_x_d     = cg_x;
               pix_y_d     = cg_y;
               pix_valid_d = 1'b1;
               state_d     = EMIT;
            end
         end
         EMIT: begin
            if (pix_ready) begin
               pix_valid_d = 1'b0;
               if (cg_last_pixel) begin
                  frame_done_d = 1'b1;
                  state_d      = IDLE;
               end else begin
                  cg_advance = 1'b1;
                  state_d    = LAUNCH;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         frame_done_q <= 1'b0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_count_q  <= '0;
         iters_q      <= '0;
      end else begin
         state_q      <= state_d;
         frame_done_q <= frame_done_d;
         pix_valid_q  <= pix_valid_d;
         pix_x_q      <= pix_x_d;
         pix_y_q      <= pix_y_d;
         pix_count_q  <= pix_count_d;
         iters_q      <= iters_d;
      end
   end

`ifdef MAND_DISPATCHER_STATS_EN
   logic [31:0] conv_q, conv_d, max_q, max_d;
   logic        xfer, start_acc;

   assign xfer          = (state_q == EMIT) && pix_ready;
   assign start_acc     = (state_q == IDLE) && start;
   assign converged_cnt = conv_q;
   assign max_count     = max_q;

   always_comb begin
      conv_d = conv_q;
      max_d  = max_q;
      if (start_acc) begin
         conv_d = '0;
         max_d  = '0;
      end else if (xfer) begin
         // Negative counts other than -1 are not meaningful and are ignored.
         if (pix_count_q == RESULT_CONVERGED) begin
            conv_d = conv_q + 32'd1;
         end else if (!pix_count_q[31] && (pix_count_q > max_q)) begin
            max_d = pix_count_q;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         conv_q <= '0;
         max_q  <= '0;
      end else begin
         conv_q <= conv_d;
         max_q  <= max_d;
      end
   end
`endif
endmodule

// File: tb/tb_mand_dispatcher.sv
// Scoreboard bench for mand_dispatcher on a 2x2 grid with a behavioural solver model.
// Define MAND_DISPATCHER_STATS_EN to also check the statistics outputs.
module tb_mand_dispatcher;
   localparam int W = 2;
   localparam int H = 2;
   localparam int XW = 2;
   localparam int YW = 2;
   localparam int REC_W = XW + YW + 32;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [26:0] x_min = '0, y_max = '0, step = '0;
   logic [9:0]  iter_limit = '0;
   logic        busy, frame_done, solver_reset;
   logic [26:0] solver_c_re, solver_c_im;
   logic [9:0]  solver_iters;
   logic        solver_out_ready;
   logic [31:0] solver_out;
   logic        pix_valid;
   logic        pix_ready = 1'b1;
   logic [XW-1:0] pix_x;
   logic [YW-1:0] pix_y;
   logic [31:0] pix_count;
   logic [1:0]  dbg_state;
`ifdef MAND_DISPATCHER_STATS_EN
   logic [31:0] converged_cnt, max_count;
`endif

   mand_dispatcher #(.WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW)) dut (
      .clock(clock), .reset(reset), .start(start),
      .x_min(x_min), .y_max(y_max), .step(step), .iter_limit(iter_limit),
      .busy(busy), .frame_done(frame_done), .solver_reset(solver_reset),
      .solver_c_re(solver_c_re), .solver_c_im(solver_c_im), .solver_iters(solver_iters),
      .solver_out_ready(solver_out_ready), .solver_out(solver_out),
      .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_x(pix_x), .pix_y(pix_y), .pix_count(pix_count),
`ifdef MAND_DISPATCHER_STATS_EN
      .converged_cnt(converged_cnt), .max_count(max_count),
`endif
      .dbg_state(dbg_state)
   );

   // clock / reset
   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Q4.23 value in quarter units: q4(n) = n * 0.25
   function automatic logic [26:0] q4(input int n);
      return 27'(n * (1 << 21));
   endfunction

   // behavioural solver: result after lat cycles, ready held until the next launch
   logic [31:0] res_q[$];
   int lat = 4;
   int m_cnt = 0;
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         solver_out_ready <= 1'b0;
         solver_out       <= '0;
         m_cnt            <= 0;
      end else if (solver_reset) begin
         solver_out_ready <= 1'b0;
         m_cnt            <= lat;
      end else if (m_cnt > 0) begin
         m_cnt <= m_cnt - 1;
         if (m_cnt == 1) begin
            solver_out_ready <= 1'b1;
            solver_out       <= (res_q.size() > 0) ? res_q.pop_front() : 32'hDEAD_BEEF;
         end
      end
   end

   // scoreboard
   logic [REC_W-1:0] exp_q[$];
   logic [53:0]      exp_c_q[$];
   logic [9:0]       exp_iters = '0;
   int stall_len = 0;
   int stall_left = 0;
   logic prev_valid = 1'b0;
   logic [REC_W-1:0] snap;
   int done_pulses = 0;
   int xfers = 0;
   int launches = 0;

   // monitor: also drives pix_ready so the transfer decision and the check agree
   always @(negedge clock) begin
      if (reset) begin
         if (solver_reset) begin
            launches++;
            if (exp_c_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL launch_unexpected: c=(%0h,%0h) with empty queue", solver_c_re, solver_c_im);
            end else begin
               check("launch_c", {10'd0, solver_c_re, solver_c_im}, {10'd0, exp_c_q.pop_front()});
               check("launch_iters", {54'd0, solver_iters}, {54'd0, exp_iters});
            end
         end
         if (pix_valid) begin
            if (!prev_valid) begin
               snap = {pix_x, pix_y, pix_count};
               stall_left = stall_len;
            end else begin
               check("hold_stable", {28'd0, pix_x, pix_y, pix_count}, {28'd0, snap});
               check("no_launch_in_stall", {63'd0, solver_reset}, 64'd0);
            end
            if (stall_left > 0) begin
               pix_ready = 1'b0;
               stall_left--;
            end else begin
               pix_ready = 1'b1;
               xfers++;
               if (exp_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL pix_unexpected: x=%0d y=%0d cnt=%0h", pix_x, pix_y, pix_count);
               end else begin
                  check("pix_record", {28'd0, pix_x, pix_y, pix_count}, {28'd0, exp_q.pop_front()});
               end
            end
         end else begin
            pix_ready = 1'b1;
         end
         prev_valid = pix_valid;
         if (frame_done) begin
            done_pulses++;
            check("busy_at_done", {63'd0, busy}, 64'd0);
         end
      end else begin
         prev_valid = 1'b0;
         pix_ready  = 1'b1;
      end
   end

   // driver tasks
   task automatic push_pix(input int x, input int y, input logic [31:0] cnt);
      exp_q.push_back({XW'(x), YW'(y), cnt});
      res_q.push_back(cnt);
   endtask

   task automatic push_c(input int re, input int im);
      exp_c_q.push_back({q4(re), q4(im)});
   endtask

   task automatic start_frame(input int xm, input int ym, input int st, input logic [9:0] it);
      @(negedge clock);
      x_min = q4(xm); y_max = q4(ym); step = q4(st); iter_limit = it;
      exp_iters = it;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      // later config changes must not reach the frame in flight
      x_min = 27'($urandom_range(0, 1000000));
      y_max = 27'($urandom_range(0, 1000000));
      step = 27'($urandom_range(1, 1000000));
      iter_limit = 10'($urandom_range(0, 1023));
   endtask

   task automatic finish_frame(input string name, input int d0, input int x0);
      int n;
      n = 0;
      while (done_pulses == d0 && n < 400) begin
         @(negedge clock);
         n++;
      end
      check({name, "_done_in_time"}, {63'd0, done_pulses > d0}, 64'd1);
      repeat (3) @(negedge clock);
      check({name, "_one_done_pulse"}, 64'(done_pulses), 64'(d0 + 1));
      check({name, "_busy_low"}, {63'd0, busy}, 64'd0);
      check({name, "_pixel_total"}, 64'(xfers - x0), 64'(W * H));
      check({name, "_queues_drained"}, 64'(exp_q.size() + exp_c_q.size()), 64'd0);
   endtask

   task automatic flush_all();
      exp_q.delete();
      exp_c_q.delete();
      res_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, x0, l0, n;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_state", {62'd0, dbg_state}, 64'd0);
      check("rst_flags", {59'd0, busy, frame_done, solver_reset, pix_valid, solver_out_ready}, 64'd0);
      check("rst_pix", {28'd0, pix_x, pix_y, pix_count}, 64'd0);
      check("rst_solver", {10'd0, solver_c_re, solver_c_im}, 64'd0);
      check("rst_iters", {54'd0, solver_iters}, 64'd0);
`ifdef MAND_DISPATCHER_STATS_EN
      check("rst_stats", {converged_cnt, max_count}, 64'd0);
`endif
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Frame A: x_min=-2.0, y_max=1.0, step=0.5, result 3 everywhere
      lat = 4; stall_len = 0;
      push_c(-8, 4); push_c(-6, 4); push_c(-8, 2); push_c(-6, 2);
      push_pix(0, 0, 32'd3); push_pix(1, 0, 32'd3); push_pix(0, 1, 32'd3); push_pix(1, 1, 32'd3);
      d0 = done_pulses; x0 = xfers;
      start_frame(-8, 4, 2, 10'd7);
      check("busy_after_start", {63'd0, busy}, 64'd1);
      finish_frame("frameA", d0, x0);
`ifdef MAND_DISPATCHER_STATS_EN
      check("frameA_stats", {converged_cnt, max_count}, {32'd0, 32'd3});
`endif

      // Frame B: 5-cycle backpressure per pixel, distinct results (stale ready visible in LAUNCH)
      lat = 4; stall_len = 5;
      push_c(0, 0); push_c(4, 0); push_c(0, -4); push_c(4, -4);
      push_pix(0, 0, 32'd5); push_pix(1, 0, 32'hFFFF_FFFF); push_pix(0, 1, 32'd9); push_pix(1, 1, 32'd2);
      d0 = done_pulses; x0 = xfers;
      start_frame(0, 0, 4, 10'd3);
      finish_frame("frameB", d0, x0);
`ifdef MAND_DISPATCHER_STATS_EN
      check("frameB_stats", {converged_cnt, max_count}, {32'd1, 32'd9});
`endif

      // Frame C: minimum solver latency, start re-pulsed mid-frame with other config
      lat = 1; stall_len = 1;
      push_c(-4, -4); push_c(-3, -4); push_c(-4, -5); push_c(-3, -5);
      push_pix(0, 0, 32'd1); push_pix(1, 0, 32'd2); push_pix(0, 1, 32'd3); push_pix(1, 1, 32'd4);
      d0 = done_pulses; x0 = xfers;
      start_frame(-4, -4, 1, 10'd10);
      repeat (6) @(negedge clock);
      x_min = q4(20); iter_limit = 10'd99; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      finish_frame("frameC", d0, x0);

      // Frame D: reset while waiting on pixel (1,0)
      lat = 4; stall_len = 0;
      push_c(2, 2); push_c(4, 2);
      push_pix(0, 0, 32'd7); res_q.push_back(32'd8);
      l0 = launches;
      start_frame(2, 2, 2, 10'd5);
      n = 0;
      while (launches < l0 + 2 && n < 100) begin
         @(negedge clock);
         n++;
      end
      check("frameD_second_launch", {63'd0, launches >= l0 + 2}, 64'd1);
      @(negedge clock);
      check("frameD_in_wait", {62'd0, dbg_state}, 64'd2);
      #2 reset = 1'b0;
      #1;
      check("async_rst_state", {62'd0, dbg_state}, 64'd0);
      check("async_rst_flags", {60'd0, busy, frame_done, solver_reset, pix_valid}, 64'd0);
      check("async_rst_pix", {28'd0, pix_x, pix_y, pix_count}, 64'd0);
      check("async_rst_solver", {10'd0, solver_c_re, solver_c_im}, 64'd0);
      check("async_rst_iters", {54'd0, solver_iters}, 64'd0);
`ifdef MAND_DISPATCHER_STATS_EN
      check("async_rst_stats", {converged_cnt, max_count}, 64'd0);
`endif
      flush_all();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // Frame E: fresh config after reset starts at (0,0)
      lat = 3; stall_len = 0;
      push_c(-1, 1); push_c(0, 1); push_c(-1, 0); push_c(0, 0);
      push_pix(0, 0, 32'd6); push_pix(1, 0, 32'd5); push_pix(0, 1, 32'd4); push_pix(1, 1, 32'hFFFF_FFFF);
      d0 = done_pulses; x0 = xfers;
      start_frame(-1, 1, 1, 10'd2);
      finish_frame("frameE", d0, x0);
`ifdef MAND_DISPATCHER_STATS_EN
      check("frameE_stats", {converged_cnt, max_count}, {32'd1, 32'd6});
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mand_dispatcher.md
Name: mand_dispatcher

Overview:
- Frame-level initiator for one mand_solver instance.
- Walks a WIDTH x HEIGHT pixel grid in raster order and computes each pixel's c in Q4.23.
- For each pixel: launches the solver, waits for its result, and emits one pixel record on a valid/ready stream to the downstream framebuffer writer.
- Sits between the host/config registers and the solver; is the driving end of the solver's c/reset/out_ready interface.

Parameters:
- WIDTH, 640, pixels per row (>=1).
- HEIGHT, 480, rows per frame (>=1).
- XW, 10, width of pix_x (must hold WIDTH-1).
- YW, 9, width of pix_y (must hold HEIGHT-1).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (low = reset asserted).
- start  in  1  one-cycle frame request; ignored unless idle.
- x_min  in  27  signed Q4.23 real part of column 0.
- y_max  in  27  signed Q4.23 imaginary part of row 0.
- step  in  27  signed Q4.23 pixel pitch.
- iter_limit  in  10  passed to the solver as convergence_iterations.
- busy  out  1  high from the cycle after an accepted start until frame_done.
- frame_done  out  1  one-cycle pulse after the last pixel handshake.
- solver_reset  out  1  active-high synchronous launch pulse to the solver.
- solver_c_re  out  27  c real part for the solver.
- solver_c_im  out  27  c imaginary part for the solver.
- solver_iters  out  10  latched iter_limit.
- solver_out_ready  in  1  solver done.
- solver_out  in  32  signed iteration count; -1 means converged.
- pix_valid  out  1  pixel record valid.
- pix_ready  in  1  downstream accepts.
- pix_x  out  XW  column index.
- pix_y  out  YW  row index.
- pix_count  out  32  latched solver_out.

Behaviour:
- Reset values (async assert when reset low): state IDLE; busy, frame_done, solver_reset, pix_valid = 0; pix_x, pix_y, pix_count, solver_c_re, solver_c_im, solver_iters = 0.
- IDLE: when start=1, latch x_min, y_max, step and iter_limit. Set c_re=x_min, c_im=y_max, x=0, y=0. Go to LAUNCH.
- LAUNCH: one cycle. solver_reset=1 with the current c on solver_c_re/solver_c_im. solver_out_ready is NOT sampled in this state, because it may still hold the previous pixel's value. Go to WAIT.
- WAIT: when solver_out_ready=1, register pix_count=solver_out and pix_x/pix_y = current x/y. Set pix_valid=1 and go to EMIT. There is no timeout; the solver always terminates within iter_limit+2 cycles.
- EMIT:
  - pix_valid, pix_x, pix_y and pix_count are held stable until pix_ready=1. A transfer occurs on a clock edge with pix_valid and pix_ready both high.
  - On transfer, pix_valid drops. If x<WIDTH-1: x+1, c_re += step, go to LAUNCH. Otherwise x=0, c_re=x_min, c_im -= step, y+1.
  - If the transferred pixel was (WIDTH-1, HEIGHT-1): frame_done pulses next cycle, busy drops, go to IDLE.
- Minimum per-pixel latency: LAUNCH(1) + solver + capture(1) + handshake(1).
- Arithmetic: 27-bit two's-complement add/sub, wrap on overflow with no saturation. c is held in accumulators; there are no multipliers.
- start while busy: ignored, and latched config is unaffected. Config input changes mid-frame have no effect.
- Reset mid-frame: immediate return to IDLE, all outputs cleared, and the partial frame is abandoned.
- pix_ready high while pix_valid low: no effect.
- WIDTH=1 or HEIGHT=1: the row wrap and frame end occur on the same transfer as appropriate.

Optional Feature:
- Macro: MAND_DISPATCHER_STATS_EN.
- When defined, adds an output converged_cnt (32) and an output max_count (32).
  - converged_cnt: number of transferred pixels with pix_count == -1 in the current/last frame.
  - max_count: largest non-negative pix_count in that frame.
  - Both clear on an accepted start and on reset, and update on each transfer.
- When undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - COORD_W=27 and FRAC_W=23 (Q4.23);
  - RESULT_CONVERGED=32'hFFFF_FFFF;
  - the state encoding IDLE/LAUNCH/WAIT/EMIT.
- One natural sub-module: mand_coord_gen. It contains the x/y counters and the c_re/c_im accumulators, with inputs load and advance, and outputs last_in_row and last_pixel.
- The FSM and stream register stay in mand_dispatcher.

Test Plan:
- 2x2 frame, x_min=-2.0 (-2<<23), y_max=1.0, step=0.5, behavioural solver returns 3 after 4 cycles -> solver_c sequence (-2,1), (-1.5,1), (-2,0.5), (-1.5,0.5); four records (0,0) (1,0) (0,1) (1,1) with count 3; frame_done one pulse; busy low after.
- Backpressure: pix_ready held low 5 cycles during EMIT -> pix_valid and pix_x/pix_y/pix_count stable, no solver_reset issued until transfer.
- Stale ready: solver model keeps out_ready=1 from the prior pixel -> dispatcher ignores it in LAUNCH; pix_count reflects the new result only.
- start pulsed mid-frame with a different x_min -> ignored; remaining c values follow the original config; pixel total = WIDTH*HEIGHT.
- Reset driven low while in WAIT on pixel (1,0) -> outputs zero asynchronously; a new start after release begins at (0,0) with fresh config.
- Integration with a real mand_solver, 1x2 frame, x_min=0, step=2.0, y_max=0, iter_limit=10 -> pixel 0 count -1 (converged; converged_cnt=1 with STATS_EN); pixel 1 c=(2,0) count 0.
